// File: rtl/mult_acc_pkg.sv
// Shared definitions for the multiply-accumulate path: FSM states, default
// widths and the product width the multiplier wrapper also uses.
package mult_acc_pkg;

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    localparam int unsigned ACC_W_DEF = 12;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned PROD_W    = 8;

endpackage

// File: rtl/mult_accumulator_sat_add.sv
// Unsigned saturating adder: the sum clamps to all-ones on carry-out,
// and sat_o reports that the clamp happened.
module sat_add #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         sat_o
);

    logic [W:0] full;

    assign full  = {1'b0, a_i} + {1'b0, b_i};
    assign sat_o = full[W];
    assign sum_o = full[W] ? '1 : full[W-1:0];

endmodule

// File: rtl/mult_accumulator.sv
// Sums a stream of unsigned products into a saturating accumulator and
// hands the sum, term count and overflow flag out on a second handshake.
module mult_accumulator
    import mult_acc_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_ovf
);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   acc_sum;
    logic [CNT_W-1:0]   cnt_sum;
    logic               acc_sat;
    logic               cnt_sat;

    sat_add #(.W(ACC_W)) u_acc_add (
        .a_i   (acc_q),
        .b_i   (ACC_W'(in_prod)),
        .sum_o (acc_sum),
        .sat_o (acc_sat)
    );

    sat_add #(.W(CNT_W)) u_cnt_add (
        .a_i   (cnt_q),
        .b_i   (CNT_W'(1)),
        .sum_o (cnt_sum),
        .sat_o (cnt_sat)
    );

    // Handshake outputs come from state alone, so no input-to-output path.
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign out_sum   = acc_q;
    assign out_cnt   = cnt_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_ACC: begin
                if (in_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_sum;
                    ovf_d = ovf_q | acc_sat | cnt_sat;
                    if (in_last) begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mult_accumulator.sv
// Bench for mult_accumulator: a cycle table, hand sequences for the
// multi-cycle corners, and a random run against an unbounded-integer model.
module tb_mult_accumulator;

    localparam int unsigned ACC_W   = 12;
    localparam int unsigned CNT_W   = 8;
    localparam int          SUM_MAX = (1 << ACC_W) - 1;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    int checks = 0;
    int errors = 0;

    // Model: true (unclamped) running sum and count plus a pending flag.
    bit m_busy = 0;
    int m_sum  = 0;
    int m_cnt  = 0;

    mult_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] prod;
        logic       last;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic       chk_d;
        int         e_sum;
        int         e_cnt;
        logic       e_ovf;
    } vec_t;

    function automatic vec_t mkv(logic r, logic v, int p, logic l, logic o,
                                 logic ir, logic ov, logic cd, int s, int c, logic f);
        vec_t x;
        x.rst = r; x.iv = v; x.prod = p[7:0]; x.last = l; x.ordy = o;
        x.e_ir = ir; x.e_ov = ov; x.chk_d = cd; x.e_sum = s; x.e_cnt = c; x.e_ovf = f;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d", nm, act, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input int s, input int c, input logic f);
        chk({nm, ".sum"}, 32'(out_sum), 32'(s));
        chk({nm, ".cnt"}, 32'(out_cnt), 32'(c));
        chk({nm, ".ovf"}, 32'(out_ovf), 32'(f));
    endtask

    // One clock: drive inputs, advance the model at the edge, check DUT against it.
    task automatic step(input logic r, input logic v, input logic [7:0] p,
                        input logic l, input logic o);
        bit was_busy;
        rst = r; in_valid = v; in_prod = p; in_last = l; out_ready = o;
        @(posedge clk);
        was_busy = m_busy;
        if (r) begin
            m_busy = 0; m_sum = 0; m_cnt = 0;
        end else if (!was_busy) begin
            if (v) begin
                m_sum += int'(p);
                m_cnt += 1;
                if (l) m_busy = 1;
            end
        end else if (o) begin
            m_busy = 0; m_sum = 0; m_cnt = 0;
        end
        #1;
        chk("model.in_ready", 32'(in_ready), 32'(!m_busy));
        chk("model.out_valid", 32'(out_valid), 32'(m_busy));
        if (m_busy || r) begin
            chk_data("model", (m_sum > SUM_MAX) ? SUM_MAX : m_sum,
                     (m_cnt > CNT_MAX) ? CNT_MAX : m_cnt,
                     (m_sum > SUM_MAX) || (m_cnt > CNT_MAX));
        end
    endtask

    initial begin
        vec_t tbl[$];

        rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;

        // Cycle table: reset, 6+20+225, a stray last on an idle cycle, single zero beat.
        tbl.push_back(mkv(1, 0,   0, 0, 0,  1, 0, 1,   0, 0, 0));
        tbl.push_back(mkv(0, 1,   6, 0, 1,  1, 0, 0,   0, 0, 0));
        tbl.push_back(mkv(0, 0,  99, 1, 1,  1, 0, 0,   0, 0, 0));
        tbl.push_back(mkv(0, 1,  20, 0, 1,  1, 0, 0,   0, 0, 0));
        tbl.push_back(mkv(0, 1, 225, 1, 1,  0, 1, 1, 251, 3, 0));
        tbl.push_back(mkv(0, 0,   0, 0, 1,  1, 0, 0,   0, 0, 0));
        tbl.push_back(mkv(0, 1,   0, 1, 1,  0, 1, 1,   0, 1, 0));
        tbl.push_back(mkv(0, 0,   0, 0, 1,  1, 0, 0,   0, 0, 0));
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].iv, tbl[i].prod, tbl[i].last, tbl[i].ordy);
            chk($sformatf("tbl%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].chk_d)
                chk_data($sformatf("tbl%0d", i), tbl[i].e_sum, tbl[i].e_cnt, tbl[i].e_ovf);
        end

        // Nineteen beats of 225 saturate the sum; the next sum starts clean.
        for (int i = 0; i < 19; i++) step(0, 1, 8'd225, (i == 18), 0);
        chk_data("sat19", 4095, 19, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0);
        step(0, 1, 2, 1, 0);
        chk_data("after_sat", 3, 2, 0);
        step(0, 0, 0, 0, 1);

        // Output stall with a beat of 9 waiting, then release.
        step(0, 1, 5, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 9, 1, 0);
            chk($sformatf("stall%0d.in_ready", i), 32'(in_ready), 32'(0));
            chk($sformatf("stall%0d.out_valid", i), 32'(out_valid), 32'(1));
            chk_data($sformatf("stall%0d", i), 5, 1, 0);
        end
        step(0, 1, 9, 1, 1);
        chk("release.in_ready", 32'(in_ready), 32'(1));
        step(0, 1, 9, 1, 1);
        chk("held_beat.out_valid", 32'(out_valid), 32'(1));
        chk_data("held_beat", 9, 1, 0);
        step(0, 0, 0, 0, 1);

        // Reset mid-sum discards the partial result.
        step(0, 1, 50, 0, 0);
        step(0, 1, 60, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_mid.in_ready", 32'(in_ready), 32'(1));
        chk_data("rst_mid", 0, 0, 0);
        step(0, 1, 7, 1, 0);
        chk_data("after_rst", 7, 1, 0);
        step(0, 0, 0, 0, 1);

        // Reset wins over an accepted last beat in the same cycle.
        step(0, 1, 10, 0, 0);
        step(1, 1, 10, 1, 1);
        chk("rst_last.out_valid", 32'(out_valid), 32'(0));
        chk_data("rst_last", 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_last_idle.out_valid", 32'(out_valid), 32'(0));

        // Count saturation: 300 zero beats.
        for (int i = 0; i < 300; i++) step(0, 1, 0, (i == 299), 0);
        chk_data("cnt_sat", 0, 255, 1);
        step(0, 0, 0, 0, 1);

        // Random traffic; later phase uses rare last to reach sum saturation.
        for (int i = 0; i < 4000; i++) begin
            logic r, v, l, o;
            logic [7:0] p;
            r = ($urandom_range(199) == 0);
            v = ($urandom_range(3) != 0);
            l = (i < 2000) ? ($urandom_range(5) == 0) : ($urandom_range(59) == 0);
            o = ($urandom_range(1) == 0);
            p = ($urandom_range(3) == 0) ? 8'($urandom_range(255))
                                         : 8'($urandom_range(15) * $urandom_range(15));
            step(r, v, p, l, o);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_accumulator.md
# mult_accumulator

Downstream consumer of the 4x4 array multiplier. Accepts a stream of unsigned 8-bit products over a valid/ready handshake and sums them into a saturating accumulator. When it accepts the term flagged last, it presents the sum, the term count and an overflow flag on an output handshake. The top level places it between the multiplier's product bus and the output pins, turning the combinational multiplier into a sequential multiply-accumulate path.

## Interface
Parameters:
- `ACC_W`, 12: accumulator and result width; must be at least 8.
- `CNT_W`, 8: term-counter width.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `in_valid`  in  1  product beat present.
- `in_ready`  out  1  block can accept a beat.
- `in_prod`  in  8  unsigned product from the multiplier.
- `in_last`  in  1  this beat closes the current sum.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  ACC_W  accumulated sum, saturated.
- `out_cnt`  out  CNT_W  number of beats in the sum, saturated.
- `out_ovf`  out  1  sticky: the sum or the count saturated at least once.

## Operation
- Two-state FSM:
  - ACC: `in_ready`=1, `out_valid`=0.
  - OUT: `in_ready`=0, `out_valid`=1.
- ACC, beat accepted (`in_valid`&`in_ready`):
  - acc ← min(acc + in_prod, 2^ACC_W−1).
  - cnt ← min(cnt+1, 2^CNT_W−1).
  - ovf ← ovf | sum saturated | count saturated.
  - If `in_last`=1, go to OUT.
- ACC, no beat accepted: all registers hold.
- OUT:
  - `out_sum`, `out_cnt` and `out_ovf` are driven from the registers and are stable while `out_valid`=1 and `out_ready`=0.
  - On `out_valid`&`out_ready`: acc, cnt and ovf clear to 0; go to ACC.
- `in_valid` during OUT is ignored; the producer holds the beat because `in_ready`=0.
- A single-beat sum (the first accepted beat has `in_last`=1) is legal: `out_cnt`=1.
- A zero-valued product still counts as a term.
- Inputs not on an accepted beat (`in_prod`, `in_last`) have no effect.

## Timing
- Reset (`rst`=1 at a clock edge):
  - FSM goes to ACC; acc, cnt, ovf go to 0.
  - Outputs after that edge: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_cnt`=0, `out_ovf`=0.
  - Reset takes priority over any handshake in the same cycle. Reset mid-sum or while in OUT discards the partial or pending result.
- Latency:
  - Accepting a last beat at edge N gives `out_valid`=1 after edge N, and the sum includes that beat.
  - The output handshake at edge M gives `in_ready`=1 after M.
- No bypass: `in_ready` is 0 for the whole OUT period, including the cycle of the output handshake. Minimum period between results is 2 cycles (one-beat sums with `out_ready` tied high).
- `in_ready` and `out_valid` depend only on the FSM state, with no combinational path from `in_valid` or `out_ready`.

## Structure
- Shared package `mult_acc_pkg` holds:
  - the state enum `{ST_ACC, ST_OUT}`;
  - the defaults `ACC_W_DEF`=12 and `CNT_W_DEF`=8;
  - the product width constant `PROD_W`=8, shared with the multiplier wrapper.
- One sub-module, `sat_add`:
  - parameterised width, unsigned operands;
  - outputs the saturated sum and a `sat` flag;
  - instantiated once for the accumulator and once for the counter.
- FSM and registers live in `mult_accumulator`.

## Test plan
- Reset, then beats 6, 20, 225 with `in_last` on the 225 beat, `out_ready`=1 → one cycle of `out_valid`: `out_sum`=251, `out_cnt`=3, `out_ovf`=0. `in_ready`=0 in that cycle and 1 in the next.
- Single beat 0 with `in_last`=1 → `out_sum`=0, `out_cnt`=1, `out_ovf`=0.
- Nineteen beats of 225 (15×15), the last flagged → `out_sum`=4095, `out_cnt`=19, `out_ovf`=1. The next sum, beats 1 and 2, gives `out_sum`=3, `out_ovf`=0 (flag cleared).
- `out_ready`=0 for 5 cycles after a result while `in_valid`=1 with `in_prod`=9 → outputs held stable, `in_ready`=0, beat not consumed. The beat is accepted the cycle after `out_ready` rises and the handshake completes.
- `rst` asserted after beats 50 and 60 (no last) → outputs at reset values. Beat 7 flagged last then gives `out_sum`=7, `out_cnt`=1.
- `rst` asserted in the same cycle as an accepted last beat → no `out_valid`, all registers 0.
